// File: rtl/id_branch_stage.sv
// id_branch_stage: IF/ID pipeline register with ID-stage branch resolution, PC redirect and perf counters
// Ports: clk/rst (async active-low); if_* fetch inputs; ext_flush/stall/forwardA/forwardB control;
//        rs1_data/rs2_data/ex_mem_alu_result operands; id_* registered IF/ID outputs and decoded fields;
//        branch_taken/branch_target/pc_write_en/id_ex_bubble combinational; br/taken/stall_cnt saturating.
module id_branch_stage #(
  parameter int          XLEN  = 32,
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [31:0]      if_inst,
  input  logic             if_valid,
  input  logic             ext_flush,
  input  logic             stall,
  input  logic             forwardA,
  input  logic             forwardB,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  ex_mem_alu_result,
  output logic [XLEN-1:0]  id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [4:0]       id_opcode,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic             branch_taken,
  output logic [XLEN-1:0]  branch_target,
  output logic             pc_write_en,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [4:0] OPCODE_Branch = 5'b11000;
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
  state_t state, stateNext;
  logic [XLEN-1:0] opA, opB, bImm;
  logic [2:0] funct3;
  logic isBr, cond, eq, lt, ltu;
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c, input logic e);
    return (e && !(&c)) ? c + 1'b1 : c;
  endfunction
  assign id_opcode = id_inst[6:2];
  assign id_rs1    = id_inst[19:15];
  assign id_rs2    = id_inst[24:20];
  assign funct3    = id_inst[14:12];
  always_comb begin
    opA           = forwardA ? ex_mem_alu_result : rs1_data;
    opB           = forwardB ? ex_mem_alu_result : rs2_data;
    bImm          = {{(XLEN-12){id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
    eq            = opA == opB;
    lt            = $signed(opA) < $signed(opB);
    ltu           = opA < opB;
    cond          = funct3 == 3'b000 ? eq  :
                    funct3 == 3'b001 ? !eq :
                    funct3 == 3'b100 ? lt  :
                    funct3 == 3'b101 ? !lt :
                    funct3 == 3'b110 ? ltu :
                    funct3 == 3'b111 ? !ltu : 1'b0;
    isBr          = id_valid && id_opcode == OPCODE_Branch;
    branch_taken  = isBr && cond && !stall && !ext_flush;
    branch_target = id_valid ? id_pc + bImm : '0;
    pc_write_en   = !stall || ext_flush;
    id_ex_bubble  = stall || ext_flush || !id_valid;
    // FLUSH ignores stall: its IF/ID slot is a NOP, so there is nothing to hold.
    stateNext     = ext_flush                       ? FLUSH :
                    state == FLUSH                  ? RUN   :
                    stall                           ? HOLD  :
                    (state == RUN && branch_taken)  ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      id_pc     <= '0;
      id_inst   <= NOP;
      id_valid  <= 1'b0;
      br_cnt    <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= stateNext;
      br_cnt    <= satInc(br_cnt, isBr && !stall && !ext_flush);
      taken_cnt <= satInc(taken_cnt, branch_taken);
      stall_cnt <= satInc(stall_cnt, stall && isBr);
      if (ext_flush || branch_taken) begin
        id_pc    <= if_pc;
        id_inst  <= NOP;
        id_valid <= 1'b0;
      end else if (!stall) begin
        id_pc    <= if_pc;
        id_inst  <= if_inst;
        id_valid <= if_valid;
      end
    end
  end
endmodule

// File: tb/tb_id_branch_stage.sv
// tb_id_branch_stage: table-driven and sequence checks for id_branch_stage
module tb_id_branch_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] if_pc = '0, if_inst = NOP, rs1_data = '0, rs2_data = '0, ex_mem_alu_result = '0;
  logic if_valid = 1'b0, ext_flush = 1'b0, stall = 1'b0, forwardA = 1'b0, forwardB = 1'b0;
  logic [31:0] id_pc, id_inst, branch_target;
  logic id_valid, branch_taken, pc_write_en, id_ex_bubble;
  logic [4:0] id_opcode, id_rs1, id_rs2;
  logic [3:0] br_cnt, taken_cnt, stall_cnt;
  int nChecks = 0, nFail = 0;
  id_branch_stage #(.XLEN(32), .CNT_W(4), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .ext_flush(ext_flush), .stall(stall), .forwardA(forwardA), .forwardB(forwardB),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_mem_alu_result(ex_mem_alu_result),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc_write_en(pc_write_en), .id_ex_bubble(id_ex_bubble),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc, inst;
    logic valid, stl, fl, fa, fb;
    logic [31:0] r1, r2, exm;
    logic taken;
    logic [31:0] tgt;
    logic pcWe, bub;
  } vec_t;
  vec_t vecs[14];
  function automatic logic [31:0] bInst(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic load(input logic [31:0] pc, input logic [31:0] inst, input logic valid);
    stall = 0; ext_flush = 0; forwardA = 0; forwardB = 0;
    if_pc = '0; if_inst = NOP; if_valid = 0;
    tick;
    if_pc = pc; if_inst = inst; if_valid = valid;
    tick;
  endtask
  initial begin
    vecs[0]  = '{32'h100, bInst(3'b000, 13'h010), 1, 0, 0, 0, 0, 32'd5, 32'd5, 32'd0, 1, 32'h110, 1, 0};
    vecs[1]  = '{32'h100, bInst(3'b001, 13'h010), 1, 0, 0, 1, 0, 32'd3, 32'd7, 32'd7, 0, 32'h110, 1, 0};
    vecs[2]  = '{32'h200, bInst(3'b100, 13'h008), 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 32'h208, 1, 0};
    vecs[3]  = '{32'h200, bInst(3'b110, 13'h008), 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 32'h208, 1, 0};
    vecs[4]  = '{32'h100, bInst(3'b000, 13'h1FF0), 1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 1, 32'h0F0, 1, 0};
    vecs[5]  = '{32'h300, bInst(3'b101, 13'h020), 1, 0, 0, 0, 1, 32'd5, 32'd9, 32'd5, 1, 32'h320, 1, 0};
    vecs[6]  = '{32'h040, bInst(3'b111, 13'h004), 1, 0, 0, 0, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 32'h044, 1, 0};
    vecs[7]  = '{32'h100, bInst(3'b010, 13'h010), 1, 0, 0, 0, 0, 32'd4, 32'd4, 32'd0, 0, 32'h110, 1, 0};
    vecs[8]  = '{32'h100, bInst(3'b001, 13'h010), 1, 1, 0, 0, 0, 32'd1, 32'd2, 32'd0, 0, 32'h110, 0, 1};
    vecs[9]  = '{32'h100, bInst(3'b000, 13'h010), 1, 1, 1, 0, 0, 32'd6, 32'd6, 32'd0, 0, 32'h110, 1, 1};
    vecs[10] = '{32'h100, ADDI, 1, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 32'h900, 1, 0};
    vecs[11] = '{32'h100, bInst(3'b000, 13'h010), 0, 0, 0, 0, 0, 32'd5, 32'd5, 32'd0, 0, 32'h0, 1, 1};
    vecs[12] = '{32'hFFFF_FFF8, bInst(3'b000, 13'h010), 1, 0, 0, 0, 0, 32'd1, 32'd1, 32'd0, 1, 32'h8, 1, 0};
    vecs[13] = '{32'h1000, bInst(3'b100, 13'h1000), 1, 0, 0, 0, 0, 32'd1, 32'd2, 32'd0, 1, 32'h0, 1, 0};
    tick; tick;
    check("rst id_pc", id_pc, 32'h0);
    check("rst id_inst", id_inst, NOP);
    check("rst id_valid", {31'd0, id_valid}, 32'd0);
    check("rst taken", {31'd0, branch_taken}, 32'd0);
    check("rst target", branch_target, 32'h0);
    check("rst bubble", {31'd0, id_ex_bubble}, 32'd1);
    check("rst cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, 32'd0);
    rst = 1;
    for (int i = 0; i < 14; i++) begin
      load(vecs[i].pc, vecs[i].inst, vecs[i].valid);
      stall = vecs[i].stl; ext_flush = vecs[i].fl; forwardA = vecs[i].fa; forwardB = vecs[i].fb;
      rs1_data = vecs[i].r1; rs2_data = vecs[i].r2; ex_mem_alu_result = vecs[i].exm;
      #1;
      check($sformatf("vec%0d taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].taken});
      check($sformatf("vec%0d target", i), branch_target, vecs[i].tgt);
      check($sformatf("vec%0d pc_write_en", i), {31'd0, pc_write_en}, {31'd0, vecs[i].pcWe});
      check($sformatf("vec%0d bubble", i), {31'd0, id_ex_bubble}, {31'd0, vecs[i].bub});
    end
    load(32'h100, bInst(3'b000, 13'h010), 1);
    rs1_data = 5; rs2_data = 5; stall = 1;
    #2 rst = 0;
    #1;
    check("async id_valid", {31'd0, id_valid}, 32'd0);
    check("async id_inst", id_inst, NOP);
    check("async id_pc", id_pc, 32'h0);
    check("async cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, 32'd0);
    tick;
    stall = 0;
    rst = 1;
    load(32'h100, bInst(3'b000, 13'h010), 1);
    rs1_data = 5; rs2_data = 5;
    #1;
    check("A taken", {31'd0, branch_taken}, 32'd1);
    check("A target", branch_target, 32'h110);
    check("A fields", {17'd0, id_opcode, id_rs1, id_rs2}, {17'd0, 5'b11000, 5'd1, 5'd2});
    if_pc = 32'h104; if_inst = ADDI; if_valid = 1;
    tick;
    check("A flush valid", {31'd0, id_valid}, 32'd0);
    check("A flush inst", id_inst, NOP);
    check("A flush pc", id_pc, 32'h104);
    check("A cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, {20'd0, 4'd1, 4'd1, 4'd0});
    load(32'h100, bInst(3'b000, 13'h010), 1);
    stall = 1;
    #1;
    check("B stall taken", {31'd0, branch_taken}, 32'd0);
    check("B stall pcwe", {31'd0, pc_write_en}, 32'd0);
    check("B stall bubble", {31'd0, id_ex_bubble}, 32'd1);
    if_pc = 32'h200; if_inst = ADDI; if_valid = 1;
    tick;
    check("B held pc", id_pc, 32'h100);
    check("B held valid", {31'd0, id_valid}, 32'd1);
    check("B stall_cnt", {28'd0, stall_cnt}, 32'd1);
    stall = 0;
    #1;
    check("B retaken", {31'd0, branch_taken}, 32'd1);
    tick;
    check("B flush valid", {31'd0, id_valid}, 32'd0);
    check("B flush pc", id_pc, 32'h200);
    check("B cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, {20'd0, 4'd2, 4'd2, 4'd1});
    load(32'h300, bInst(3'b001, 13'h010), 1);
    forwardA = 1; ex_mem_alu_result = 7; rs1_data = 3; rs2_data = 7;
    #1;
    check("C taken", {31'd0, branch_taken}, 32'd0);
    check("C pcwe", {31'd0, pc_write_en}, 32'd1);
    if_pc = 32'h400; if_inst = ADDI; if_valid = 1;
    tick;
    check("C adv pc", id_pc, 32'h400);
    check("C adv inst", id_inst, ADDI);
    check("C adv valid", {31'd0, id_valid}, 32'd1);
    check("C br_cnt", {28'd0, br_cnt}, 32'd3);
    load(32'h100, bInst(3'b000, 13'h010), 1);
    rs1_data = 5; rs2_data = 5; stall = 1; ext_flush = 1;
    #1;
    check("D taken", {31'd0, branch_taken}, 32'd0);
    check("D pcwe", {31'd0, pc_write_en}, 32'd1);
    check("D bubble", {31'd0, id_ex_bubble}, 32'd1);
    if_pc = 32'h500; if_inst = ADDI; if_valid = 1;
    tick;
    check("D inst", id_inst, NOP);
    check("D valid", {31'd0, id_valid}, 32'd0);
    check("D pc", id_pc, 32'h500);
    check("D cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, {20'd0, 4'd3, 4'd2, 4'd2});
    for (int i = 0; i < 16; i++) load(32'h100, bInst(3'b000, 13'h010), 1);
    tick;
    check("E sat cnts", {20'd0, br_cnt, taken_cnt, stall_cnt}, {20'd0, 4'd15, 4'd15, 4'd2});
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
